// File: rtl/checkers_pkg.sv
// Shared types and constants for the checkers board manager:
// piece/status codes, FSM states and the start-of-game layout.
package checkers_pkg;

   typedef enum logic [2:0] {
      EMPTY = 3'd0,
      P1    = 3'd1,
      P2    = 3'd2,
      K1    = 3'd3,
      K2    = 3'd4
   } piece_t;

   typedef enum logic [1:0] {
      OK         = 2'd0,
      ILLEGAL    = 2'd1,
      OK_CAPTURE = 2'd2
   } status_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_APPLY = 2'd2,
      S_RESP  = 2'd3
   } fsm_t;

   typedef logic [63:0][2:0] board_t;

   localparam int SQ_PITCH_DEF = 14;

   // Men on dark squares ((row+col) odd): P1 on rows 0-2, P2 on rows 5-7.
   function automatic board_t start_layout();
      board_t b;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            if (((r + c) % 2) == 0) begin
               b[r*8+c] = EMPTY;
            end else if (r < 3) begin
               b[r*8+c] = P1;
            end else if (r > 4) begin
               b[r*8+c] = P2;
            end else begin
               b[r*8+c] = EMPTY;
            end
         end
      end
      return b;
   endfunction

endpackage

// File: rtl/move_checker.sv
// Combinational legality check for one checkers move: ownership, target
// square, direction, step/jump geometry and jumped-piece ownership.
module move_checker
   import checkers_pkg::*;
(
   input  logic [2:0] src_piece,
   input  logic [2:0] dst_piece,
   input  logic [2:0] mid_piece,
   input  logic [2:0] src_row,
   input  logic [2:0] src_col,
   input  logic [2:0] dst_row,
   input  logic [2:0] dst_col,
   input  logic       turn,
   output logic       legal,
   output logic       capture,
   output logic       promote
);

   logic [3:0] dr_s;
   logic [3:0] dc_s;
   logic [3:0] adr_s;
   logic [3:0] adc_s;
   logic       own_s;
   logic       opp_mid_s;
   logic       dir_ok_s;
   logic       step_s;
   logic       jump_s;

   // Geometry and rule evaluation; dr/dc are 4-bit two's complement
   always_comb begin
      dr_s      = {1'b0, dst_row} - {1'b0, src_row};
      dc_s      = {1'b0, dst_col} - {1'b0, src_col};
      adr_s     = dr_s[3] ? (4'd0 - dr_s) : dr_s;
      adc_s     = dc_s[3] ? (4'd0 - dc_s) : dc_s;
      own_s     = 1'b0;
      opp_mid_s = 1'b0;
      dir_ok_s  = 1'b0;
      if (turn) begin
         own_s     = (src_piece == P2) || (src_piece == K2);
         opp_mid_s = (mid_piece == P1) || (mid_piece == K1);
      end else begin
         own_s     = (src_piece == P1) || (src_piece == K1);
         opp_mid_s = (mid_piece == P2) || (mid_piece == K2);
      end
      if ((src_piece == K1) || (src_piece == K2)) begin
         dir_ok_s = 1'b1;
      end else if (src_piece == P1) begin
         dir_ok_s = ~dr_s[3];
      end else begin
         dir_ok_s = dr_s[3];
      end
      step_s  = (adr_s == 4'd1) && (adc_s == 4'd1);
      jump_s  = (adr_s == 4'd2) && (adc_s == 4'd2);
      legal   = own_s && (dst_piece == EMPTY) && (dst_row[0] ^ dst_col[0]) &&
                ({src_row, src_col} != {dst_row, dst_col}) && dir_ok_s &&
                (step_s || (jump_s && opp_mid_s));
      capture = legal && jump_s;
      promote = legal && (((src_piece == P1) && (dst_row == 3'd7)) ||
                          ((src_piece == P2) && (dst_row == 3'd0)));
   end

endmodule

// File: rtl/board_state_mgr.sv
// Checkers board owner: applies move commands through a 4-state FSM and
// maps the video beam position to a square for the icon renderer.
module board_state_mgr
   import checkers_pkg::*;
#(
   parameter int SQ_PITCH = SQ_PITCH_DEF,
   parameter int BOARD_X0 = 0,
   parameter int BOARD_Y0 = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] vid_row,
   input  logic [9:0] vid_col,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [5:0] cmd_src,
   input  logic [5:0] cmd_dst,
   input  logic       cmd_new_game,
   output logic       resp_valid,
   output logic [1:0] resp_status,
   output logic       turn,
   output logic [7:0] locX,
   output logic [7:0] locY,
   output logic [7:0] icon_state
);

   // Boundaries are compared against the unscaled video address (x4), which
   // equals comparing vid>>2 against the scaled boundary.
   localparam logic [11:0] X0_4 = 12'(4 * BOARD_X0);
   localparam logic [11:0] Y0_4 = 12'(4 * BOARD_Y0);

   fsm_t       state_r;
   board_t     board_r;
   logic       turn_r;
   logic       cmd_ready_r;
   logic       resp_valid_r;
   logic [1:0] status_r;
   logic [5:0] src_r;
   logic [5:0] dst_r;
   logic       ng_r;
   logic       legal_r;
   logic       capture_r;
   logic       promote_r;
   logic [7:0] loc_x_r;
   logic [7:0] loc_y_r;
   logic [7:0] icon_r;

   logic [6:0] idx_sum_s;
   logic [5:0] mid_idx_s;
   logic       chk_legal_s;
   logic       chk_capture_s;
   logic       chk_promote_s;
   logic [3:0] col_q_s;
   logic [3:0] row_q_s;
   logic [5:0] rd_idx_s;
   logic [7:0] loc_x_s;
   logic [7:0] loc_y_s;
   logic [7:0] icon_s;

   // Returns {off_board, square}: square counts crossed boundaries, clamped to 7.
   function automatic logic [3:0] sq_of(input logic [9:0] v, input logic [11:0] org4);
      logic [2:0] s;
      logic       off;
      s = 3'd0;
      for (int k = 1; k < 8; k++) begin
         s = s + {2'b00, ({2'b00, v} >= (org4 + 12'(4 * k * SQ_PITCH)))};
      end
      off = ({2'b00, v} < org4) || ({2'b00, v} >= (org4 + 12'(32 * SQ_PITCH)));
      return {off, s};
   endfunction

   assign idx_sum_s = {1'b0, src_r} + {1'b0, dst_r};
   assign mid_idx_s = 6'(idx_sum_s >> 1);

   move_checker u_move_checker (
      .src_piece (board_r[src_r]),
      .dst_piece (board_r[dst_r]),
      .mid_piece (board_r[mid_idx_s]),
      .src_row   (src_r[5:3]),
      .src_col   (src_r[2:0]),
      .dst_row   (dst_r[5:3]),
      .dst_col   (dst_r[2:0]),
      .turn      (turn_r),
      .legal     (chk_legal_s),
      .capture   (chk_capture_s),
      .promote   (chk_promote_s)
   );

   // Command FSM and board storage
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= S_IDLE;
         board_r      <= start_layout();
         turn_r       <= 1'b0;
         cmd_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
         status_r     <= OK;
         src_r        <= 6'd0;
         dst_r        <= 6'd0;
         ng_r         <= 1'b0;
         legal_r      <= 1'b0;
         capture_r    <= 1'b0;
         promote_r    <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               resp_valid_r <= 1'b0;
               if (cmd_valid && cmd_ready_r) begin
                  src_r       <= cmd_src;
                  dst_r       <= cmd_dst;
                  ng_r        <= cmd_new_game;
                  cmd_ready_r <= 1'b0;
                  state_r     <= S_CHECK;
               end
            end
            S_CHECK: begin
               legal_r   <= chk_legal_s;
               capture_r <= chk_capture_s;
               promote_r <= chk_promote_s;
               state_r   <= S_APPLY;
            end
            S_APPLY: begin
               if (ng_r) begin
                  board_r  <= start_layout();
                  turn_r   <= 1'b0;
                  status_r <= OK;
               end else if (legal_r) begin
                  if (promote_r) begin
                     board_r[dst_r] <= (board_r[src_r] == P1) ? K1 : K2;
                  end else begin
                     board_r[dst_r] <= board_r[src_r];
                  end
                  board_r[src_r] <= EMPTY;
                  if (capture_r) begin
                     board_r[mid_idx_s] <= EMPTY;
                  end
                  turn_r   <= ~turn_r;
                  status_r <= capture_r ? OK_CAPTURE : OK;
               end else begin
                  status_r <= ILLEGAL;
               end
               resp_valid_r <= 1'b1;
               state_r      <= S_RESP;
            end
            S_RESP: begin
               resp_valid_r <= 1'b0;
               cmd_ready_r  <= 1'b1;
               state_r      <= S_IDLE;
            end
            default: begin
               resp_valid_r <= 1'b0;
               cmd_ready_r  <= 1'b1;
               state_r      <= S_IDLE;
            end
         endcase
      end
   end

   // Beam-to-square lookup; reads the board before any same-cycle write
   always_comb begin
      col_q_s  = sq_of(vid_col, X0_4);
      row_q_s  = sq_of(vid_row, Y0_4);
      rd_idx_s = {row_q_s[2:0], col_q_s[2:0]};
      loc_x_s  = 8'(BOARD_X0 + int'(col_q_s[2:0]) * SQ_PITCH);
      loc_y_s  = 8'(BOARD_Y0 + int'(row_q_s[2:0]) * SQ_PITCH);
      if (col_q_s[3] || row_q_s[3]) begin
         icon_s = 8'd0;
      end else begin
         icon_s = {5'd0, board_r[rd_idx_s]};
      end
   end

   // Display output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         loc_x_r <= 8'(BOARD_X0);
         loc_y_r <= 8'(BOARD_Y0);
         icon_r  <= 8'd0;
      end else begin
         loc_x_r <= loc_x_s;
         loc_y_r <= loc_y_s;
         icon_r  <= icon_s;
      end
   end

   assign cmd_ready   = cmd_ready_r;
   assign resp_valid  = resp_valid_r;
   assign resp_status = status_r;
   assign turn        = turn_r;
   assign locX        = loc_x_r;
   assign locY        = loc_y_r;
   assign icon_state  = icon_r;

endmodule
